// File: rtl/ioctl_upload_reader.sv
// Upload-side byte server: fetches core memory bytes over a toggle req/ack port
// and keeps the next byte ready on ioctl_din before the host asks for it.
//
// state | meaning
// IDLE  | no transfer, or start requested while an abandoned ack is still due
// FETCH | memory read outstanding for cur_addr
// READY | ioctl_din holds the byte for cur_addr
module ioctl_upload_reader #(
  parameter int         ADDR_W = 16,
  parameter int         UP_LEN = 256,
  parameter logic [7:0] FILL   = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [7:0]        mem_dout,
  output logic              busy,
  output logic              overrun
);
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, READY = 2'd2} state_t;

  // One extra bit so UP_LEN == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] LEN_X = (ADDR_W+1)'(UP_LEN);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic              pending;
  logic              upload_q;
  logic              start_wait;

  logic              rise;
  logic              ack_match;
  logic              do_issue;
  logic              issue_ok;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] issue_addr;

  assign rise       = ioctl_upload & ~upload_q;
  assign ack_match  = (mem_ack == mem_req);
  assign next_addr  = cur_addr + ADDR_W'(1);
  assign issue_addr = (state == IDLE) ? '0 : next_addr;
  assign issue_ok   = ({1'b0, issue_addr} < LEN_X);

  // A new request may only go out once the previous toggle has been answered.
  always_comb begin
    do_issue = 1'b0;
    if (ioctl_upload) begin
      case (state)
        IDLE:    do_issue = (rise | start_wait) & ack_match;
        FETCH:   do_issue = ack_match & (pending | ioctl_rd);
        READY:   do_issue = ioctl_rd;
        default: do_issue = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cur_addr   <= '0;
      pending    <= 1'b0;
      upload_q   <= 1'b0;
      start_wait <= 1'b0;
      ioctl_din  <= FILL;
      mem_addr   <= '0;
      mem_req    <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      upload_q <= ioctl_upload;
      if (!ioctl_upload) begin
        state      <= IDLE;
        pending    <= 1'b0;
        busy       <= 1'b0;
        start_wait <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              overrun    <= 1'b0;
              cur_addr   <= '0;
              start_wait <= ~ack_match;
            end else if (start_wait && ack_match) begin
              start_wait <= 1'b0;
            end
          end
          FETCH: begin
            if (ack_match) begin
              ioctl_din <= mem_dout;
              busy      <= 1'b0;
              pending   <= 1'b0;
              state     <= READY;
              if (pending && ioctl_rd) overrun <= 1'b1;
            end else if (ioctl_rd) begin
              if (pending) overrun <= 1'b1;
              else         pending <= 1'b1;
            end
          end
          READY: begin
          end
          default: state <= IDLE;
        endcase

        // Issue overrides the FETCH completion above when an advance follows it.
        if (do_issue) begin
          if (state != IDLE) cur_addr <= next_addr;
          if (issue_ok) begin
            mem_addr <= issue_addr;
            mem_req  <= ~mem_req;
            busy     <= 1'b1;
            state    <= FETCH;
          end else begin
            ioctl_din <= FILL;
            busy      <= 1'b0;
            state     <= READY;
          end
        end
      end
    end
  end

endmodule
